// File: rtl/prio_rr_arbiter.sv
// prio_rr_arbiter: one-hot grant arbiter with hold limit; ARB_ROUND_ROBIN_EN selects round-robin over fixed priority.
module prio_rr_arbiter #(
  parameter int N = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [N-1:0]         req,
  input  logic                 done,
  output logic [N-1:0]         gnt,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 preempt
);
  localparam int IDW = $clog2(N);
  localparam int HW = MAX_HOLD > 0 ? $clog2(MAX_HOLD + 1) : 1;
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
  state_t state, state_n;
  logic [HW-1:0] hold, hold_n;
  logic [IDW-1:0] win, gnt_id_n;
  logic [N-1:0] gnt_n;
  logic pick, hit_limit, rel, preempt_n;
`ifdef ARB_ROUND_ROBIN_EN
  logic [IDW-1:0] last_id;
  // descending k leaves the nearest requester after last_id as the winner
  always_comb begin
    win = '0;
    for (int k = N; k >= 1; k--)
      if (req[(int'(last_id) + k) % N]) win = IDW'((int'(last_id) + k) % N);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) last_id <= IDW'(N - 1);
    else if (pick) last_id <= win;
`else
  always_comb begin
    win = '0;
    for (int i = 0; i < N; i++)
      if (req[i]) win = IDW'(i);
  end
`endif
  assign pick = (state != GRANT) && en && (|req);
  assign hit_limit = (MAX_HOLD != 0) && (int'(hold) + 1 >= MAX_HOLD);
  assign rel = done || !req[gnt_id] || hit_limit;
  assign gnt_valid = |gnt;
  always_comb begin
    state_n = state;
    gnt_n = gnt;
    gnt_id_n = gnt_id;
    hold_n = hold;
    preempt_n = 1'b0;
    if (state == GRANT) begin
      if (rel) begin
        state_n = GAP;
        gnt_n = '0;
        gnt_id_n = '0;
        preempt_n = hit_limit && !done && req[gnt_id];
      end else begin
        hold_n = (int'(hold) >= MAX_HOLD) ? hold : hold + 1'b1;
      end
    end else if (pick) begin
      state_n = GRANT;
      gnt_n = '0;
      gnt_n[win] = 1'b1;
      gnt_id_n = win;
      hold_n = '0;
    end else begin
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      gnt <= '0;
      gnt_id <= '0;
      hold <= '0;
      preempt <= 1'b0;
    end else begin
      state <= state_n;
      gnt <= gnt_n;
      gnt_id <= gnt_id_n;
      hold <= hold_n;
      preempt <= preempt_n;
    end
endmodule

// File: tb/tb_prio_rr_arbiter.sv
// tb_prio_rr_arbiter: scoreboard bench; a grant-ownership model predicts each cycle's outputs.
module tb_prio_rr_arbiter;
  localparam int N = 4;
  localparam int MAX_HOLD = 8;
  localparam int IDW = $clog2(N);
  logic clk = 1'b0, reset = 1'b1, en = 1'b0, done = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt;
  logic gnt_valid, preempt;
  logic [IDW-1:0] gnt_id;
  int total = 0, bad = 0;
  typedef struct {logic [N-1:0] g; logic v; logic [IDW-1:0] id; logic p;} exp_t;
  exp_t q[$];
  int owner = -1, held = 0, last = N - 1;
  always #5 clk = ~clk;
  prio_rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset(reset), .en(en), .req(req), .done(done),
    .gnt(gnt), .gnt_valid(gnt_valid), .gnt_id(gnt_id), .preempt(preempt)
  );
  function automatic int choose(logic [N-1:0] r);
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
`else
    for (int i = N - 1; i >= 0; i--) if (r[i]) return i;
`endif
    return -1;
  endfunction
  task automatic check(string name, logic [N+IDW+1:0] act, logic [N+IDW+1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s t=%0t: got {gnt,valid,id,preempt}=%h want %h", name, $time, act, want);
    end
  endtask
  task automatic step(logic e, logic [N-1:0] r, logic d);
    exp_t x;
    logic pre;
    pre = 1'b0;
    @(negedge clk);
    en = e; req = r; done = d;
    if (owner >= 0) begin
      held++;
      if (d || !r[owner] || (MAX_HOLD > 0 && held >= MAX_HOLD)) begin
        pre = !d && r[owner];
        owner = -1;
      end
    end else if (e && r != '0) begin
      owner = choose(r);
      held = 0;
      last = owner;
    end
    x.g = '0;
    if (owner >= 0) x.g[owner] = 1'b1;
    x.v = owner >= 0;
    x.id = owner >= 0 ? IDW'(owner) : '0;
    x.p = pre;
    q.push_back(x);
  endtask
  task automatic model_reset();
    owner = -1; held = 0; last = N - 1;
    q.delete();
  endtask
  always @(posedge clk) begin
    exp_t x;
    #2;
    if (!reset && q.size() > 0) begin
      x = q.pop_front();
      check("cycle", {gnt, gnt_valid, gnt_id, preempt}, {x.g, x.v, x.id, x.p});
    end
  end
  initial begin
    logic [N-1:0] r;
    #12;
    check("reset_outputs", {gnt, gnt_valid, gnt_id, preempt}, '0);
    @(negedge clk);
    reset = 1'b0;
    step(1, 4'b0101, 0);
    step(1, 4'b0101, 1);
    step(0, 4'b0000, 0);
    for (int i = 0; i < 10; i++) step(1, 4'b1111, i[0]);
    step(1, 4'b1111, 1);
    step(0, 4'b0000, 0);
    for (int i = 0; i < 5; i++) step(0, 4'b0010, 0);
    step(1, 4'b0010, 0);
    for (int i = 0; i < 3; i++) step(0, 4'b0010, 0);
    step(0, 4'b0010, 1);
    for (int i = 0; i < 3; i++) step(0, 4'b0010, 0);
    step(0, 4'b0000, 0);
    for (int i = 0; i < 12; i++) step(1, 4'b0011, 0);
    step(1, 4'b0011, 1);
    step(0, 4'b0000, 0);
    step(1, 4'b0100, 0);
    step(1, 4'b0000, 1);
    step(0, 4'b0000, 0);
    step(1, 4'b0100, 0);
    step(1, 4'b0100, 0);
    @(posedge clk);
    #3;
    en = 1'b0; req = '0; reset = 1'b1;
    #1;
    check("async_reset", {gnt, gnt_valid, gnt_id, preempt}, '0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    step(1, 4'b1111, 0);
    step(1, 4'b1111, 1);
    r = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 3) r = N'($urandom_range(0, (1 << N) - 1));
      step($urandom_range(0, 7) != 0, r, $urandom_range(0, 5) == 0);
    end
    step(0, 4'b0000, 1);
    @(posedge clk);
    #3;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/prio_rr_arbiter.md
# prio_rr_arbiter

Sequential arbiter that shares one downstream resource among N requesters. Each cycle it holds at most one registered one-hot grant. A grant lasts until the grantee signals completion, withdraws its request, or exceeds a hold limit. Selection is fixed-priority (highest index wins, matching the team's priority-encoder ordering) or round-robin, chosen at compile time. It sits between the requester ports and the shared datapath and drives that datapath's select/enable.

## Interface
- N, 4: number of requesters; legal range 2..8.
- MAX_HOLD, 8: maximum consecutive GRANT cycles before forced release; 0 = unlimited.
- IDW, $clog2(N): width of gnt_id; localparam, not overridable.
- clk  input  1  sole clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- en  input  1  arbitration enable; gates new grants only.
- req  input  N  request vector; bit i = requester i.
- done  input  1  current grantee finished; sampled only while gnt_valid=1.
- gnt  output  N  one-hot grant, registered; all zero when no grant.
- gnt_valid  output  1  high exactly when gnt is nonzero.
- gnt_id  output  IDW  binary index of the granted requester; 0 when gnt_valid=0.
- preempt  output  1  one-cycle pulse in the first GAP cycle after a hold-limit release.

## Operation
- States:
  - IDLE: no grant.
  - GRANT: one requester owns the resource.
  - GAP: single turnaround cycle with gnt=0.
- IDLE: if en=1 and req≠0, pick a winner and go to GRANT. Otherwise stay in IDLE.
- GRANT release conditions, evaluated at each edge:
  - done=1,
  - or req[gnt_id]=0,
  - or hold count reached MAX_HOLD.
  - Any one of these moves the FSM to GAP. If several occur together, it is a single release. preempt is set only when the hold limit is the sole cause.
- en=0 during GRANT does not abort the grant. It blocks only the next selection.
- GAP: if en=1 and req≠0, pick a winner and go to GRANT. Otherwise go to IDLE. The released requester may win again if the selection policy allows it.
- Hold counter:
  - Cleared on entry to GRANT.
  - Increments each GRANT cycle; saturates at MAX_HOLD.
  - Width is $clog2(MAX_HOLD+1); minimum 1.
  - With MAX_HOLD=0 the counter is unused.
- Round-robin pointer last_id:
  - Updated to the winner on every grant.
  - Search order is last_id+1, last_id+2, … modulo N, wrapping at N-1 to 0.
- done while gnt_valid=0 is ignored.
- Request bits at or above N do not exist. Inputs that are not one-hot need no special handling.

## Timing
- Reset values: state=IDLE, gnt=0, gnt_valid=0, gnt_id=0, preempt=0, hold count=0, last_id=N-1. The first round-robin search therefore starts at requester 0.
- Grant latency: req sampled at edge t from IDLE gives gnt valid after edge t.
- Release: release condition sampled at edge t gives gnt=0 after edge t (GAP). The next grant can be valid after edge t+1. Minimum gap between consecutive grants is 1 cycle.
- Hold limit: gnt stays high for exactly MAX_HOLD cycles, then GAP with preempt=1 for that one cycle.
- gnt, gnt_valid and gnt_id change on the same edge and are always mutually consistent.
- Reset asserted mid-grant clears all outputs asynchronously, without waiting for a clock edge. After reset deasserts, the first edge behaves as IDLE.

## Configuration
- ARB_ROUND_ROBIN_EN defined: winner is the first requesting index after last_id, modulo N, and last_id is tracked.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, highest requesting index wins. last_id logic is not compiled, and the reset value of last_id does not apply.
- Release rules, hold limit, GAP and timing are identical in both builds.

## Test plan
All scenarios use N=4 and MAX_HOLD=8.
- Reset/first grant: after reset all outputs 0. Then en=1, req=4'b0101 → one edge later: round-robin build gnt=0001, gnt_id=0; fixed build gnt=0100, gnt_id=2.
- Rotation (round-robin build): req=1111 held, done pulsed once per grant → gnt sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001. Fixed build under the same stimulus → 1000 each time, with GAP between.
- Enable gating: en=0, req=0010 for 5 cycles → gnt stays 0. Deassert en mid-grant → grant holds until done, then IDLE, with no further grant while en=0.
- Hold limit (round-robin build): req=0011 held, done=0 → gnt=0001 for exactly 8 cycles, then 1 GAP cycle with preempt=1, then gnt=0010.
- Request withdrawal plus simultaneous events: grantee drops req in the same cycle done=1 → one release, one GAP cycle, preempt=0.
- Reset mid-grant: assert reset while gnt=0100 → gnt, gnt_valid and gnt_id go to 0 before the next edge. After release with req=1111, the round-robin build grants 0001.
